// File: rtl/upconverter_param_pkg.sv
// Shared types and constants for the parameterised I/Q upconverter.
// FSM state encoding, mode encodings and default sizing.
package upconverter_param_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic MODE_ZSTUFF = 1'b0;
  localparam logic MODE_HOLD   = 1'b1;

  localparam int DEF_OS      = 4;
  localparam int DEF_NB_DATA = 1;

endpackage

// File: rtl/upconv_lane.sv
// One upsampling lane (I or Q): registers the slot value from the
// next-state slot counter and symbol/mode/phase selected by the top.
module upconv_lane
  import upconverter_param_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_CNT  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_emit,
  input  logic               i_mode,
  input  logic [NB_CNT-1:0]  i_slot,
  input  logic [NB_CNT-1:0]  i_phase,
  input  logic [NB_DATA-1:0] i_sym,
  output logic [NB_DATA-1:0] o_up
);

  logic [NB_DATA-1:0] w_up_nxt;
  logic [NB_DATA-1:0] r_up;

  // slot value selection for the coming cycle
  always_comb begin
    w_up_nxt = {NB_DATA{1'b0}};
    if (i_emit) begin
      case (i_mode)
        MODE_HOLD:   w_up_nxt = i_sym;
        MODE_ZSTUFF: begin
          if (i_slot == i_phase) begin
            w_up_nxt = i_sym;
          end else begin
            w_up_nxt = {NB_DATA{1'b0}};
          end
        end
        default:     w_up_nxt = {NB_DATA{1'b0}};
      endcase
    end else begin
      w_up_nxt = {NB_DATA{1'b0}};
    end
  end

  // output register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_up <= {NB_DATA{1'b0}};
    end else begin
      r_up <= w_up_nxt;
    end
  end

  assign o_up = r_up;

endmodule

// File: rtl/upconverter_param.sv
// Parameterised I/Q upconverter: each accepted symbol becomes OS output
// slots, zero-stuffed at a chosen phase or sample-held, with overrun flag.
module upconverter_param
  import upconverter_param_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int OS      = DEF_OS,
  parameter int NB_CNT  = $clog2(OS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_sym_I,
  input  logic [NB_DATA-1:0] i_sym_Q,
  input  logic               i_mode,
  input  logic [NB_CNT-1:0]  i_phase,
  input  logic               i_clr,
  output logic [NB_DATA-1:0] o_up_I,
  output logic [NB_DATA-1:0] o_up_Q,
  output logic               o_valid,
  output logic [NB_CNT-1:0]  o_slot,
  output logic               o_overrun
);

  localparam logic [NB_CNT:0]   L_OS   = (NB_CNT+1)'(OS);
  localparam logic [NB_CNT-1:0] L_LAST = NB_CNT'(OS - 1);
  localparam logic [NB_CNT-1:0] L_ONE  = NB_CNT'(1);

  state_t             r_state, w_state_nxt;
  logic [NB_CNT-1:0]  r_cnt, w_cnt_nxt;
  logic [NB_DATA-1:0] r_sym_I, r_sym_Q, w_sym_I_nxt, w_sym_Q_nxt;
  logic               r_mode, w_mode_nxt;
  logic [NB_CNT-1:0]  r_phase, w_phase_nxt, w_phase_clamp;
  logic               r_valid, r_overrun;
  logic [NB_CNT-1:0]  r_slot;
  logic               w_last, w_accept, w_drop, w_emit_nxt;

  assign w_last        = (r_state == EMIT) && (r_cnt == L_LAST);
  assign w_accept      = i_valid && ((r_state == IDLE) || w_last);
  assign w_drop        = i_valid && (r_state == EMIT) && !w_last;
  assign w_phase_clamp = ({1'b0, i_phase} >= L_OS) ? L_LAST : i_phase;
  assign w_emit_nxt    = (w_state_nxt == EMIT);

  // next-state, slot counter and symbol latch
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_state_nxt = i_valid ? EMIT : IDLE;
        w_cnt_nxt   = {NB_CNT{1'b0}};
      end
      EMIT: begin
        if (w_last) begin
          w_state_nxt = i_valid ? EMIT : IDLE;
          w_cnt_nxt   = {NB_CNT{1'b0}};
        end else begin
          w_state_nxt = EMIT;
          w_cnt_nxt   = r_cnt + L_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {NB_CNT{1'b0}};
      end
    endcase
    if (w_accept) begin
      w_sym_I_nxt = i_sym_I;
      w_sym_Q_nxt = i_sym_Q;
      w_mode_nxt  = i_mode;
      w_phase_nxt = w_phase_clamp;
    end else begin
      w_sym_I_nxt = r_sym_I;
      w_sym_Q_nxt = r_sym_Q;
      w_mode_nxt  = r_mode;
      w_phase_nxt = r_phase;
    end
  end

  // state, latch and control-output registers; dropped symbol beats clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= {NB_CNT{1'b0}};
      r_sym_I   <= {NB_DATA{1'b0}};
      r_sym_Q   <= {NB_DATA{1'b0}};
      r_mode    <= MODE_ZSTUFF;
      r_phase   <= {NB_CNT{1'b0}};
      r_valid   <= 1'b0;
      r_slot    <= {NB_CNT{1'b0}};
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sym_I <= w_sym_I_nxt;
      r_sym_Q <= w_sym_Q_nxt;
      r_mode  <= w_mode_nxt;
      r_phase <= w_phase_nxt;
      r_valid <= w_emit_nxt;
      if (w_emit_nxt) begin
        r_slot <= w_cnt_nxt;
      end else begin
        r_slot <= {NB_CNT{1'b0}};
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_clr) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  upconv_lane #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) u_lane_i (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_emit  (w_emit_nxt),
    .i_mode  (w_mode_nxt),
    .i_slot  (w_cnt_nxt),
    .i_phase (w_phase_nxt),
    .i_sym   (w_sym_I_nxt),
    .o_up    (o_up_I)
  );

  upconv_lane #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) u_lane_q (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_emit  (w_emit_nxt),
    .i_mode  (w_mode_nxt),
    .i_slot  (w_cnt_nxt),
    .i_phase (w_phase_nxt),
    .i_sym   (w_sym_Q_nxt),
    .o_up    (o_up_Q)
  );

  assign o_valid   = r_valid;
  assign o_slot    = r_slot;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_upconverter_param.sv
// Self-checking bench for upconverter_param: directed vector table,
// reset/parameter corner sequences and a queue-based random reference.
module tb_upconverter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_valid, a_I, a_Q, a_mode, a_clr;
  logic [1:0] a_phase;
  logic       a_up_I, a_up_Q, a_ovalid, a_ov;
  logic [1:0] a_slot;

  upconverter_param dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .i_sym_I(a_I), .i_sym_Q(a_Q),
    .i_mode(a_mode), .i_phase(a_phase), .i_clr(a_clr), .o_up_I(a_up_I), .o_up_Q(a_up_Q),
    .o_valid(a_ovalid), .o_slot(a_slot), .o_overrun(a_ov)
  );

  logic       b_valid, b_mode, b_clr;
  logic [3:0] b_I, b_Q;
  logic [2:0] b_phase;
  logic [3:0] c_up_I, c_up_Q, d_up_I, d_up_Q;
  logic       c_ovalid, c_ov, d_ovalid, d_ov;
  logic [2:0] c_slot, d_slot;

  upconverter_param #(.NB_DATA(4), .OS(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_sym_I(b_I), .i_sym_Q(b_Q),
    .i_mode(b_mode), .i_phase(b_phase), .i_clr(b_clr), .o_up_I(c_up_I), .o_up_Q(c_up_Q),
    .o_valid(c_ovalid), .o_slot(c_slot), .o_overrun(c_ov)
  );

  upconverter_param #(.NB_DATA(4), .OS(6)) dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_sym_I(b_I), .i_sym_Q(b_Q),
    .i_mode(b_mode), .i_phase(b_phase), .i_clr(b_clr), .o_up_I(d_up_I), .o_up_Q(d_up_Q),
    .o_valid(d_ovalid), .o_slot(d_slot), .o_overrun(d_ov)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int ev, input int eI, input int eQ,
                       input int es, input int eov);
    chk({tag, " valid"}, 32'(a_ovalid), 32'(ev));
    chk({tag, " I"},     32'(a_up_I),   32'(eI));
    chk({tag, " Q"},     32'(a_up_Q),   32'(eQ));
    chk({tag, " slot"},  32'(a_slot),   32'(es));
    chk({tag, " ovr"},   32'(a_ov),     32'(eov));
  endtask

  typedef struct {
    logic       v, I, Q, md;
    logic [1:0] ph;
    logic       clr;
    int         ev, eI, eQ, es, eov;
  } vec_t;

  function automatic vec_t mk(input int v, input int I, input int Q, input int md,
                              input int ph, input int clr, input int ev, input int eI,
                              input int eQ, input int es, input int eov);
    vec_t r;
    r.v = 1'(v); r.I = 1'(I); r.Q = 1'(Q); r.md = 1'(md); r.ph = 2'(ph); r.clr = 1'(clr);
    r.ev = ev; r.eI = eI; r.eQ = eQ; r.es = es; r.eov = eov;
    return r;
  endfunction

  typedef struct {
    int v, I, Q, slot;
  } sample_t;

  vec_t    tbl[37];
  sample_t q[$];
  sample_t cur;
  int      m_ov;

  initial begin
    // zero-stuff single symbol, phase 0
    tbl[0]  = mk(1,1,0,0,0,0, 1,1,0,0,0);
    tbl[1]  = mk(0,0,0,0,0,0, 1,0,0,1,0);
    tbl[2]  = mk(0,0,0,0,0,0, 1,0,0,2,0);
    tbl[3]  = mk(0,0,0,0,0,0, 1,0,0,3,0);
    tbl[4]  = mk(0,0,0,0,0,0, 0,0,0,0,0);
    // hold burst; mode/phase changes mid-burst must not leak in
    tbl[5]  = mk(1,1,1,1,0,0, 1,1,1,0,0);
    tbl[6]  = mk(0,0,0,0,3,0, 1,1,1,1,0);
    tbl[7]  = mk(0,0,0,0,3,0, 1,1,1,2,0);
    tbl[8]  = mk(0,0,0,0,3,0, 1,1,1,3,0);
    // zero-stuff phase 2, accepted on the last hold slot
    tbl[9]  = mk(1,1,0,0,2,0, 1,0,0,0,0);
    tbl[10] = mk(0,0,0,1,0,0, 1,0,0,1,0);
    tbl[11] = mk(0,0,0,1,0,0, 1,1,0,2,0);
    tbl[12] = mk(0,0,0,1,0,0, 1,0,0,3,0);
    tbl[13] = mk(0,0,0,0,0,0, 0,0,0,0,0);
    // back-to-back 1,0,1
    tbl[14] = mk(1,1,0,0,0,0, 1,1,0,0,0);
    tbl[15] = mk(0,0,0,0,0,0, 1,0,0,1,0);
    tbl[16] = mk(0,0,0,0,0,0, 1,0,0,2,0);
    tbl[17] = mk(0,0,0,0,0,0, 1,0,0,3,0);
    tbl[18] = mk(1,0,0,0,0,0, 1,0,0,0,0);
    tbl[19] = mk(0,0,0,0,0,0, 1,0,0,1,0);
    tbl[20] = mk(0,0,0,0,0,0, 1,0,0,2,0);
    tbl[21] = mk(0,0,0,0,0,0, 1,0,0,3,0);
    tbl[22] = mk(1,1,0,0,0,0, 1,1,0,0,0);
    tbl[23] = mk(0,0,0,0,0,0, 1,0,0,1,0);
    tbl[24] = mk(0,0,0,0,0,0, 1,0,0,2,0);
    tbl[25] = mk(0,0,0,0,0,0, 1,0,0,3,0);
    tbl[26] = mk(0,0,0,0,0,0, 0,0,0,0,0);
    // overrun at slot 1, then clear
    tbl[27] = mk(1,1,1,1,0,0, 1,1,1,0,0);
    tbl[28] = mk(0,0,0,0,0,0, 1,1,1,1,0);
    tbl[29] = mk(1,0,0,0,0,0, 1,1,1,2,1);
    tbl[30] = mk(0,0,0,0,0,1, 1,1,1,3,0);
    tbl[31] = mk(0,0,0,0,0,0, 0,0,0,0,0);
    // overrun set and clear together: set wins
    tbl[32] = mk(1,1,0,1,0,0, 1,1,0,0,0);
    tbl[33] = mk(1,0,0,0,0,1, 1,1,0,1,1);
    tbl[34] = mk(0,0,0,0,0,0, 1,1,0,2,1);
    tbl[35] = mk(0,0,0,0,0,0, 1,1,0,3,1);
    tbl[36] = mk(0,0,0,0,0,1, 0,0,0,0,0);

    a_valid = 1'b0; a_I = 1'b0; a_Q = 1'b0; a_mode = 1'b0; a_phase = 2'd0; a_clr = 1'b0;
    b_valid = 1'b0; b_I = 4'd0; b_Q = 4'd0; b_mode = 1'b0; b_phase = 3'd0; b_clr = 1'b0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_a("reset", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 chk_a("reset held", 0, 0, 0, 0, 0);
    chk("reset b valid", 32'(c_ovalid) | 32'(d_ovalid), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 37; i++) begin
      a_valid = tbl[i].v; a_I = tbl[i].I; a_Q = tbl[i].Q;
      a_mode = tbl[i].md; a_phase = tbl[i].ph; a_clr = tbl[i].clr;
      @(posedge clk);
      #1 chk_a($sformatf("row%0d", i), tbl[i].ev, tbl[i].eI, tbl[i].eQ, tbl[i].es, tbl[i].eov);
    end

    // async reset mid-burst (with overrun set) then restart on first edge
    a_valid = 1'b1; a_I = 1'b1; a_Q = 1'b1; a_mode = 1'b1; a_phase = 2'd0; a_clr = 1'b0;
    @(posedge clk);
    #1 a_valid = 1'b1; a_I = 1'b0; a_Q = 1'b0;
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(posedge clk);
    #1 chk_a("pre-reset slot2", 1, 1, 1, 2, 1);
    #3 rst_n = 1'b0;
    #1 chk_a("async reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_a("reset over edge", 0, 0, 0, 0, 0);
    rst_n = 1'b1; a_valid = 1'b1; a_I = 1'b1; a_Q = 1'b0; a_mode = 1'b0; a_phase = 2'd0;
    @(posedge clk);
    #1 chk_a("restart", 1, 1, 0, 0, 0);
    a_valid = 1'b0; a_I = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk_a("drained", 0, 0, 0, 0, 0);

    // OS=8 and OS=6 instances: phase 5 in range, phase 7 clamps to 5 on OS=6
    for (int pass = 0; pass < 2; pass++) begin
      int ph;
      ph = (pass == 0) ? 5 : 7;
      b_valid = 1'b1; b_I = 4'hA; b_Q = 4'h5; b_mode = 1'b0; b_phase = 3'(ph);
      for (int c = 0; c < 9; c++) begin
        int p6;
        @(posedge clk);
        #1;
        b_valid = 1'b0; b_I = 4'h0; b_Q = 4'h0; b_phase = 3'd0;
        p6 = (ph > 5) ? 5 : ph;
        chk($sformatf("os8 p%0d c%0d valid", ph, c), 32'(c_ovalid), (c < 8) ? 32'd1 : 32'd0);
        chk($sformatf("os8 p%0d c%0d slot", ph, c), 32'(c_slot), (c < 8) ? 32'(c) : 32'd0);
        chk($sformatf("os8 p%0d c%0d I", ph, c), 32'(c_up_I), (c == ph) ? 32'hA : 32'h0);
        chk($sformatf("os8 p%0d c%0d Q", ph, c), 32'(c_up_Q), (c == ph) ? 32'h5 : 32'h0);
        chk($sformatf("os6 p%0d c%0d valid", ph, c), 32'(d_ovalid), (c < 6) ? 32'd1 : 32'd0);
        chk($sformatf("os6 p%0d c%0d I", ph, c), 32'(d_up_I), (c == p6) ? 32'hA : 32'h0);
      end
    end

    // random traffic against a slot-queue reference model
    m_ov = 0;
    for (int c = 0; c < 600; c++) begin
      bit drop;
      a_valid = ($urandom_range(0, 2) == 0);
      a_I = 1'($urandom); a_Q = 1'($urandom); a_mode = 1'($urandom);
      a_phase = 2'($urandom); a_clr = ($urandom_range(0, 7) == 0);
      drop = 1'b0;
      if (a_valid) begin
        if (q.size() == 0) begin
          for (int s = 0; s < 4; s++) begin
            sample_t e;
            e.v = 1; e.slot = s;
            e.I = (a_mode || s == int'(a_phase)) ? int'(a_I) : 0;
            e.Q = (a_mode || s == int'(a_phase)) ? int'(a_Q) : 0;
            q.push_back(e);
          end
        end else begin
          drop = 1'b1;
        end
      end
      if (drop) m_ov = 1;
      else if (a_clr) m_ov = 0;
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{v: 0, I: 0, Q: 0, slot: 0};
      @(posedge clk);
      #1 chk_a($sformatf("rnd%0d", c), cur.v, cur.I, cur.Q, cur.slot, m_ov);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
